// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants and types for the 8-requester round-robin select arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mux_arb_pkg;

   localparam int N_REQ = 8;   // requester count, tied to the 3-bit select
   localparam int SEL_W = 3;   // select width

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // One-hot expansion of a select index.
   function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Bundle between the requesters and the select arbiter: level requests and
// per-requester data bits in, registered grant/select/valid and muxed bit out.
// Backpressure: none; requests are levels held until granted service ends.
//   master : requester side  (drives req, data_in; observes gnt, sel, valid, y)
//   slave  : arbiter side    (observes req, data_in; drives gnt, sel, valid, y)
interface mux8_rr_arbiter_if;
   import mux_arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] data_in;
   logic [N_REQ-1:0] gnt;
   logic [SEL_W-1:0] sel;
   logic             valid;
   logic             y;

   modport master (
      output req, data_in,
      input  gnt, sel, valid, y
   );

   modport slave (
      input  req, data_in,
      output gnt, sel, valid, y
   );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating priority search over 8 request bits, optionally masking one index.
// Latency: purely combinational.
// Backpressure: not applicable.
//   req_i     : request vector
//   start_i   : first index examined; search wraps modulo 8
//   excl_en_i : when set, index excl_i is never chosen
//   excl_i    : index to mask (current owner)
//   found_o   : some eligible request exists
//   idx_o     : first eligible index in rotation order (0 when none)
module rr_pick8
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [SEL_W-1:0] start_i,
   input  logic             excl_en_i,
   input  logic [SEL_W-1:0] excl_i,
   output logic             found_o,
   output logic [SEL_W-1:0] idx_o
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         // 3-bit addition wraps naturally, giving the modulo-8 rotation.
         cand = start_i + SEL_W'(k);
         if (!found_o && req_i[cand] && !(excl_en_i && (cand == excl_i))) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 one-bit mux, with a bounded
// hold time per grant. Optional build macro MUX_ARB_PRIO0_EN gives requester 0
// absolute priority at every arbitration point (never pre-empting a hold).
// Latency: req -> gnt/sel/valid 1 cycle (registered); data_in -> y combinational.
// Backpressure: none; a requester keeps req high until it no longer needs the path.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux8_rr_arbiter_if (req, data_in in; gnt, sel, valid, y out)
module mux8_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4   // consecutive cycles per grant while others wait, >= 1
)(
   input  logic               clk,
   input  logic               rst_n,
   mux8_rr_arbiter_if.slave   bus
);

   localparam int               HOLD_W    = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] gnt_q,   gnt_d;
   logic [SEL_W-1:0] sel_q,   sel_d;
   logic [SEL_W-1:0] last_q,  last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;
   logic [SEL_W-1:0] win_idx;
   logic             own_req;
   logic             hold_done;

   // While granting, the owner is masked so the search only reports other
   // pending requesters; the owner sits last in rotation because last == owner.
   rr_pick8 u_pick (
      .req_i     (bus.req),
      .start_i   (last_q + SEL_W'(1)),
      .excl_en_i (state_q == GRANT),
      .excl_i    (sel_q),
      .found_o   (pick_found),
      .idx_o     (pick_idx)
   );

`ifdef MUX_ARB_PRIO0_EN
   // Only consulted at arbitration points, so an ongoing hold is never cut short.
   // If requester 0 already owns and reaches hold expiry, it simply re-wins.
   assign win_idx = bus.req[0] ? '0 : pick_idx;
`else
   assign win_idx = pick_idx;
`endif

   assign own_req   = bus.req[sel_q];
   assign hold_done = (hold_q == HOLD_LAST);

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= SEL_W'(N_REQ - 1);   // first search therefore begins at 0
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_found) state_d = GRANT;
         GRANT:   if (!own_req && !pick_found) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant, select, rotation pointer and hold counter.
   always_comb begin
      gnt_d  = gnt_q;
      sel_d  = sel_q;
      last_d = last_q;
      hold_d = hold_q;
      case (state_q)
         IDLE: begin
            hold_d = '0;
            gnt_d  = '0;
            if (pick_found) begin
               sel_d  = win_idx;
               last_d = win_idx;
               gnt_d  = sel_to_onehot(win_idx);
            end
         end
         GRANT: begin
            if (!own_req) begin
               // Owner released: hand over directly, or drop to idle with sel held.
               hold_d = '0;
               if (pick_found) begin
                  sel_d  = win_idx;
                  last_d = win_idx;
                  gnt_d  = sel_to_onehot(win_idx);
               end else begin
                  gnt_d  = '0;
               end
            end else if (hold_done) begin
               // Hold expired: rotate if anyone else waits, otherwise restart the window.
               hold_d = '0;
               if (pick_found) begin
                  sel_d  = win_idx;
                  last_d = win_idx;
                  gnt_d  = sel_to_onehot(win_idx);
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            gnt_d  = '0;
            hold_d = '0;
         end
      endcase
   end

   assign bus.gnt   = gnt_q;
   assign bus.sel   = sel_q;
   assign bus.valid = (state_q == GRANT);
   assign bus.y     = (state_q == GRANT) ? bus.data_in[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: a behavioural arbiter model pushes
// the expected post-edge outputs into a queue as each request pattern is driven;
// the queue is popped and compared against the DUT after the edge.
module tb_mux8_rr_arbiter;
   import mux_arb_pkg::*;

   localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       valid;
      logic       y;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   mux8_rr_arbiter_if bus ();

   mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   // Behavioural model state.
   int m_busy, m_own, m_cnt, m_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0;
      m_own  = 0;
      m_cnt  = 0;
      m_last = 7;
   endtask

   // First set request after 'after' in rotation, skipping index 'skip'; -1 if none.
   function automatic int rr_search(input logic [7:0] r, input int after, input int skip);
      for (int k = 1; k <= 8; k++) begin
         int i;
         i = (after + k) % 8;
         if (r[i] && i != skip) return i;
      end
      return -1;
   endfunction

   task automatic model_take(input int w);
      m_own  = w;
      m_last = w;
      m_cnt  = 0;
      m_busy = 1;
   endtask

   task automatic model_edge(input logic [7:0] r);
      int oth;
      if (!m_busy) begin
         if (r != 8'h00) model_take((PRIO0 && r[0]) ? 0 : rr_search(r, m_last, -1));
      end else begin
         oth = rr_search(r, m_own, m_own);
         if (!r[m_own]) begin
            if (oth >= 0) model_take((PRIO0 && r[0]) ? 0 : oth);
            else begin m_busy = 0; m_cnt = 0; end
         end else if (m_cnt == MAX_HOLD - 1) begin
            if (oth >= 0) model_take((PRIO0 && r[0]) ? 0 : oth);
            else m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("sb_underflow", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk("gnt",   32'(bus.gnt),   32'(e.gnt));
         chk("sel",   32'(bus.sel),   32'(e.sel));
         chk("valid", 32'(bus.valid), 32'(e.valid));
         chk("y",     32'(bus.y),     32'(e.y));
      end
   endtask

   // Drive one cycle of stimulus at the falling edge, predict, check after the rise.
   task automatic step(input logic [7:0] r, input logic [7:0] d);
      exp_t e;
      @(negedge clk);
      bus.req     = r;
      bus.data_in = d;
      model_edge(r);
      e.gnt   = m_busy ? (8'h01 << m_own) : 8'h00;
      e.sel   = 3'(m_own);
      e.valid = (m_busy != 0);
      e.y     = m_busy ? d[m_own] : 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   // Change data mid-cycle and confirm y follows without waiting for an edge.
   task automatic live_y(input logic [7:0] d);
      bus.data_in = d;
      #1;
      chk("y_live", 32'(bus.y), m_busy ? 32'(d[m_own]) : 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req     = 8'h00;
      bus.data_in = 8'h00;
      model_reset();

      // Reset state.
      #12;
      chk("rst_gnt",   32'(bus.gnt),   32'd0);
      chk("rst_sel",   32'(bus.sel),   32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_y",     32'(bus.y),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single requester 0; y tracks data_in[0].
      step(8'h01, 8'h01);
      step(8'h01, 8'hFE);
      step(8'h01, 8'h01);
      live_y(8'h00);
      live_y(8'h01);

      // 0 and 7 contend: 4-cycle alternation with no gaps.
      for (int i = 0; i < 20; i++) step(8'h81, 8'($urandom));

      // Owner 3 releases while 5 is pending: direct handover.
      step(8'h00, 8'h00);
      step(8'h08, 8'h08);
      step(8'h28, 8'h20);
      step(8'h20, 8'h20);
      step(8'h20, 8'h00);

      // Lone requester 2 keeps the grant through hold-window wraps.
      step(8'h00, 8'h00);
      for (int i = 0; i < 10; i++) step(8'h04, 8'($urandom));
      live_y(8'h04);
      live_y(8'h00);

      // Asynchronous reset between edges mid-grant.
      step(8'h10, 8'h10);
      step(8'h10, 8'h10);
      #2;
      bus.req = 8'h00;
      rst_n   = 1'b0;
      #1;
      chk("arst_gnt",   32'(bus.gnt),   32'd0);
      chk("arst_valid", 32'(bus.valid), 32'd0);
      chk("arst_y",     32'(bus.y),     32'd0);
      chk("arst_sel",   32'(bus.sel),   32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step(8'hFF, 8'($urandom));

      // last = 5, then 0 and 6 contend.
      step(8'h00, 8'h00);
      step(8'h20, 8'h00);
      for (int i = 0; i < 12; i++) step(8'h41, 8'($urandom));

      // Random request mix.
      for (int i = 0; i < 60; i++) step(8'($urandom), 8'($urandom));
      step(8'h00, 8'h00);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
